// File: rtl/screen_arbiter.sv
// Screen RAM arbiter: the GPU line fetcher has fixed priority over the Hack CPU.
// A streak counter forces one CPU slot after STARVE_LIMIT contended GPU grants.
`timescale 1ns/1ps
module screen_arbiter #(
  parameter int BASE         = 16384,
  parameter int DEPTH        = 8192,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_gpu_req,
  input  logic [12:0] i_gpu_addr,
  output logic        o_gpu_ack,
  output logic        o_gpu_valid,
  output logic [15:0] o_gpu_rdata,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [14:0] i_cpu_addr,
  input  logic [15:0] i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic        o_cpu_valid,
  output logic [15:0] o_cpu_rdata,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [12:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata
);

  localparam int             SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [15:0]    RANGE_LO   = 16'(BASE);
  localparam logic [15:0]    RANGE_HI   = 16'(BASE + DEPTH);
  localparam logic [14:0]    BASE15     = 15'(BASE);

  logic          cpu_in_range;
  logic          cpu_in_range_req;
  logic          cpu_oor_req;
  logic          force_cpu;
  logic          grant_gpu;
  logic          grant_cpu;
  logic [12:0]   cpu_local;

  logic [SW-1:0] streak_q, streak_d;
  logic          gpu_rd_q, gpu_rd_d;
  logic          cpu_rd_q, cpu_rd_d;
  logic          cpu_oor_rd_q, cpu_oor_rd_d;
  logic [15:0]   gpu_hold_q, gpu_hold_d;
  logic [15:0]   cpu_hold_q, cpu_hold_d;

  always_comb begin
    cpu_in_range     = ({1'b0, i_cpu_addr} >= RANGE_LO) && ({1'b0, i_cpu_addr} < RANGE_HI);
    cpu_local        = 13'(i_cpu_addr - BASE15);
    cpu_in_range_req = i_cpu_req && cpu_in_range;
    cpu_oor_req      = i_cpu_req && !cpu_in_range;

    force_cpu = cpu_in_range_req && (streak_q == STREAK_MAX);
    grant_gpu = i_gpu_req && !force_cpu;
    grant_cpu = cpu_in_range_req && !grant_gpu;

    // Out-of-range CPU accesses are acked immediately and never touch the RAM.
    o_gpu_ack = grant_gpu;
    o_cpu_ack = grant_cpu || cpu_oor_req;

    o_mem_en    = grant_gpu || grant_cpu;
    o_mem_we    = grant_cpu && i_cpu_we;
    o_mem_addr  = 13'd0;
    o_mem_wdata = 16'd0;
    if (grant_gpu) begin
      o_mem_addr = i_gpu_addr;
    end else if (grant_cpu) begin
      o_mem_addr  = cpu_local;
      o_mem_wdata = i_cpu_wdata;
    end
  end

  always_comb begin
    streak_d = '0;
    if (grant_gpu && cpu_in_range_req) begin
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
    end

    gpu_rd_d     = grant_gpu;
    cpu_rd_d     = grant_cpu && !i_cpu_we;
    cpu_oor_rd_d = cpu_oor_req && !i_cpu_we;
  end

  // Read data arrives one cycle after the grant; the hold regs keep the last value.
  always_comb begin
    o_gpu_valid = gpu_rd_q;
    o_gpu_rdata = gpu_rd_q ? i_mem_rdata : gpu_hold_q;
    o_cpu_valid = cpu_rd_q || cpu_oor_rd_q;
    if (cpu_rd_q) begin
      o_cpu_rdata = i_mem_rdata;
    end else if (cpu_oor_rd_q) begin
      o_cpu_rdata = 16'd0;
    end else begin
      o_cpu_rdata = cpu_hold_q;
    end
    gpu_hold_d = o_gpu_rdata;
    cpu_hold_d = o_cpu_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q     <= '0;
      gpu_rd_q     <= 1'b0;
      cpu_rd_q     <= 1'b0;
      cpu_oor_rd_q <= 1'b0;
      gpu_hold_q   <= 16'd0;
      cpu_hold_q   <= 16'd0;
    end else begin
      streak_q     <= streak_d;
      gpu_rd_q     <= gpu_rd_d;
      cpu_rd_q     <= cpu_rd_d;
      cpu_oor_rd_q <= cpu_oor_rd_d;
      gpu_hold_q   <= gpu_hold_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

endmodule

// File: tb/tb_screen_arbiter.sv
// Scoreboard bench for screen_arbiter: directed stimulus pushes expected read data,
// a negedge monitor pops and compares whenever a valid appears.
`timescale 1ns/1ps
module tb_screen_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_gpu_req;
  logic [12:0] i_gpu_addr;
  logic        o_gpu_ack;
  logic        o_gpu_valid;
  logic [15:0] o_gpu_rdata;
  logic        i_cpu_req;
  logic        i_cpu_we;
  logic [14:0] i_cpu_addr;
  logic [15:0] i_cpu_wdata;
  logic        o_cpu_ack;
  logic        o_cpu_valid;
  logic [15:0] o_cpu_rdata;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [12:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  exp_t        gpu_q[$];
  exp_t        cpu_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic        mem_load;
  logic [15:0] mem [0:8191];
  logic [12:0] gaddr;

  always #5 clk = ~clk;

  screen_arbiter dut (
    .clk(clk), .rst(rst),
    .i_gpu_req(i_gpu_req), .i_gpu_addr(i_gpu_addr),
    .o_gpu_ack(o_gpu_ack), .o_gpu_valid(o_gpu_valid), .o_gpu_rdata(o_gpu_rdata),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_ack(o_cpu_ack), .o_cpu_valid(o_cpu_valid), .o_cpu_rdata(o_cpu_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  function automatic logic [15:0] pat(input int a);
    return 16'(a) ^ 16'hA5A5;
  endfunction

  // Screen RAM model: single port, one cycle read latency.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 8192; i++) mem[i] <= pat(i);
      mem[5] <= 16'h1234;
    end else if (o_mem_en === 1'b1) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else          i_mem_rdata <= mem[o_mem_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic greq, input logic [12:0] ga, input logic creq,
                               input logic cwe, input logic [14:0] ca, input logic [15:0] cwd);
    @(posedge clk);
    #1;
    i_gpu_req   = greq;
    i_gpu_addr  = ga;
    i_cpu_req   = creq;
    i_cpu_we    = cwe;
    i_cpu_addr  = ca;
    i_cpu_wdata = cwd;
  endtask

  task automatic cycleCheck(input string tag, input logic gack, input logic cack, input logic en,
                            input logic we, input logic [12:0] addr, input logic [15:0] wdata);
    @(negedge clk);
    checkOutput({tag, "_gpu_ack"}, 32'(o_gpu_ack), 32'(gack));
    checkOutput({tag, "_cpu_ack"}, 32'(o_cpu_ack), 32'(cack));
    checkOutput({tag, "_mem_en"},  32'(o_mem_en),  32'(en));
    checkOutput({tag, "_mem_we"},  32'(o_mem_we),  32'(we));
    if (en) begin
      checkOutput({tag, "_mem_addr"},  32'(o_mem_addr),  32'(addr));
      checkOutput({tag, "_mem_wdata"}, 32'(o_mem_wdata), 32'(wdata));
    end
  endtask

  task automatic pushGpu(input logic [15:0] d);
    exp_t e;
    e.due = cyc + 1;
    e.data = d;
    gpu_q.push_back(e);
  endtask

  task automatic pushCpu(input logic [15:0] d);
    exp_t e;
    e.due = cyc + 1;
    e.data = d;
    cpu_q.push_back(e);
  endtask

  always @(negedge clk) begin : gpu_mon
    exp_t e;
    if (o_gpu_valid === 1'b1) begin
      if (gpu_q.size() == 0 || gpu_q[0].due != cyc) begin
        checkOutput("gpu_valid_unexpected", 32'd1, 32'd0);
      end else begin
        e = gpu_q.pop_front();
        checkOutput("gpu_rdata", 32'(o_gpu_rdata), 32'(e.data));
      end
    end else if (gpu_q.size() != 0 && gpu_q[0].due <= cyc) begin
      e = gpu_q.pop_front();
      checkOutput("gpu_valid_missing", 32'd0, 32'd1);
    end
  end

  always @(negedge clk) begin : cpu_mon
    exp_t e;
    if (o_cpu_valid === 1'b1) begin
      if (cpu_q.size() == 0 || cpu_q[0].due != cyc) begin
        checkOutput("cpu_valid_unexpected", 32'd1, 32'd0);
      end else begin
        e = cpu_q.pop_front();
        checkOutput("cpu_rdata", 32'(o_cpu_rdata), 32'(e.data));
      end
    end else if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
      e = cpu_q.pop_front();
      checkOutput("cpu_valid_missing", 32'd0, 32'd1);
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mem_load = 1'b1;
    i_gpu_req = 1'b0; i_gpu_addr = '0; i_cpu_req = 1'b0; i_cpu_we = 1'b0;
    i_cpu_addr = '0; i_cpu_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    mem_load = 1'b0;
    @(negedge clk);
    checkOutput("rst_gpu_valid", 32'(o_gpu_valid), 32'd0);
    checkOutput("rst_cpu_valid", 32'(o_cpu_valid), 32'd0);
    checkOutput("rst_gpu_rdata", 32'(o_gpu_rdata), 32'd0);
    checkOutput("rst_cpu_rdata", 32'(o_cpu_rdata), 32'd0);
    checkOutput("rst_gpu_ack",   32'(o_gpu_ack),   32'd0);
    checkOutput("rst_cpu_ack",   32'(o_cpu_ack),   32'd0);
    checkOutput("rst_mem_en",    32'(o_mem_en),    32'd0);

    // GPU read of word 5
    applyStimulus(1'b1, 13'd5, 1'b0, 1'b0, 15'd0, 16'd0);
    rst = 1'b0;
    cycleCheck("gpu_rd5", 1'b1, 1'b0, 1'b1, 1'b0, 13'd5, 16'd0);
    pushGpu(16'h1234);
    applyStimulus(1'b0, 13'd0, 1'b0, 1'b0, 15'd0, 16'd0);
    cycleCheck("idle1", 1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0);
    checkOutput("gpu_rd5_no_cpu_valid", 32'(o_cpu_valid), 32'd0);

    // CPU write then read-back of 16394 (local word 10)
    applyStimulus(1'b0, 13'd0, 1'b1, 1'b1, 15'd16394, 16'hBEEF);
    cycleCheck("cpu_wr", 1'b0, 1'b1, 1'b1, 1'b1, 13'd10, 16'hBEEF);
    applyStimulus(1'b0, 13'd0, 1'b1, 1'b0, 15'd16394, 16'd0);
    cycleCheck("cpu_rd", 1'b0, 1'b1, 1'b1, 1'b0, 13'd10, 16'd0);
    pushCpu(16'hBEEF);
    applyStimulus(1'b0, 13'd0, 1'b0, 1'b0, 15'd0, 16'd0);
    cycleCheck("idle2", 1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0);

    // Contention: GPU every cycle, CPU read held; CPU forced through every 9th cycle
    gaddr = 13'd200;
    for (int j = 0; j < 18; j++) begin
      applyStimulus(1'b1, gaddr, 1'b1, 1'b0, (j <= 8) ? 15'd16404 : 15'd16405, 16'd0);
      if (j == 8 || j == 17) begin
        cycleCheck($sformatf("contend%0d", j), 1'b0, 1'b1, 1'b1, 1'b0,
                   (j == 8) ? 13'd20 : 13'd21, 16'd0);
        pushCpu((j == 8) ? pat(20) : pat(21));
      end else begin
        cycleCheck($sformatf("contend%0d", j), 1'b1, 1'b0, 1'b1, 1'b0, gaddr, 16'd0);
        pushGpu(pat(int'(gaddr)));
        gaddr = gaddr + 13'd1;
      end
    end

    // Out-of-range CPU read alongside a GPU read: both acked, RAM sees GPU only
    applyStimulus(1'b1, 13'd7, 1'b1, 1'b0, 15'd24576, 16'd0);
    cycleCheck("oor_rd_gpu", 1'b1, 1'b1, 1'b1, 1'b0, 13'd7, 16'd0);
    pushGpu(pat(7));
    pushCpu(16'd0);

    // Range boundaries: one below BASE, and the last screen word
    applyStimulus(1'b0, 13'd0, 1'b1, 1'b0, 15'd16383, 16'd0);
    cycleCheck("below_base", 1'b0, 1'b1, 1'b0, 1'b0, 13'd0, 16'd0);
    pushCpu(16'd0);
    applyStimulus(1'b0, 13'd0, 1'b1, 1'b0, 15'd24575, 16'd0);
    cycleCheck("last_word", 1'b0, 1'b1, 1'b1, 1'b0, 13'd8191, 16'd0);
    pushCpu(pat(8191));

    // Out-of-range write is dropped; word 100 keeps its initial contents
    applyStimulus(1'b0, 13'd0, 1'b1, 1'b1, 15'd100, 16'hDEAD);
    cycleCheck("oor_wr", 1'b0, 1'b1, 1'b0, 1'b0, 13'd0, 16'd0);
    applyStimulus(1'b1, 13'd100, 1'b0, 1'b0, 15'd0, 16'd0);
    cycleCheck("gpu_rd100", 1'b1, 1'b0, 1'b1, 1'b0, 13'd100, 16'd0);
    pushGpu(pat(100));

    // Build a streak of 5, reset right after a GPU grant, then the streak restarts at 0
    gaddr = 13'd300;
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1'b1, gaddr, 1'b1, 1'b0, 15'd16406, 16'd0);
      cycleCheck($sformatf("prerst%0d", j), 1'b1, 1'b0, 1'b1, 1'b0, gaddr, 16'd0);
      pushGpu(pat(int'(gaddr)));
      gaddr = gaddr + 13'd1;
    end
    applyStimulus(1'b1, gaddr, 1'b1, 1'b0, 15'd16406, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 9; j++) begin
      applyStimulus(1'b1, gaddr, 1'b1, 1'b0, 15'd16406, 16'd0);
      rst = 1'b0;
      if (j == 8) begin
        cycleCheck("postrst8", 1'b0, 1'b1, 1'b1, 1'b0, 13'd22, 16'd0);
        pushCpu(pat(22));
      end else begin
        cycleCheck($sformatf("postrst%0d", j), 1'b1, 1'b0, 1'b1, 1'b0, gaddr, 16'd0);
        if (j == 0) checkOutput("rst_drops_gpu_valid", 32'(o_gpu_valid), 32'd0);
        pushGpu(pat(int'(gaddr)));
        gaddr = gaddr + 13'd1;
      end
    end

    // Drain and confirm every expected response was seen
    applyStimulus(1'b0, 13'd0, 1'b0, 1'b0, 15'd0, 16'd0);
    repeat (3) @(negedge clk);
    checkOutput("gpu_q_drained", 32'(gpu_q.size()), 32'd0);
    checkOutput("cpu_q_drained", 32'(cpu_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/screen_arbiter.md
Name: screen_arbiter

Overview:
- Shares the single-port 8K x 16 screen RAM (Hack addresses 16384..24575) between the GPU line fetcher and the Hack CPU memory port.
- GPU fetches have fixed priority because display timing is hard real-time. A starvation guard guarantees the CPU one slot after a bounded run of GPU grants.
- Sits between the CPU bus decoder and the GPU pixel pipeline. It owns all screen RAM enables, routes read data back to the requester, and absorbs out-of-range CPU accesses.

Parameters:
- BASE, 16384, Hack address of screen word 0.
- DEPTH, 8192, screen RAM words (512x256 / 16).
- STARVE_LIMIT, 8, consecutive GPU grants allowed while CPU is pending before the CPU is forced through.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_gpu_req  in  1  GPU read request, held until ack
- i_gpu_addr  in  13  GPU word address (0..8191)
- o_gpu_ack  out  1  GPU request granted this cycle
- o_gpu_valid  out  1  GPU read data valid
- o_gpu_rdata  out  16  GPU read data
- i_cpu_req  in  1  CPU request, held until ack
- i_cpu_we  in  1  1 = write, 0 = read
- i_cpu_addr  in  15  Hack absolute address
- i_cpu_wdata  in  16  CPU write data
- o_cpu_ack  out  1  CPU request accepted this cycle
- o_cpu_valid  out  1  CPU read data valid
- o_cpu_rdata  out  16  CPU read data
- o_mem_en  out  1  RAM access enable
- o_mem_we  out  1  RAM write enable
- o_mem_addr  out  13  RAM word address
- o_mem_wdata  out  16  RAM write data
- i_mem_rdata  in  16  RAM read data, 1-cycle latency after o_mem_en with !o_mem_we

Behaviour:
- Clock, reset and interface: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: valids 0, streak 0, pending-owner 0, rdata regs 0. Acks and mem strobes are combinational and are 0 whenever no request is present.
- CPU range check: in_range = BASE <= i_cpu_addr < BASE+DEPTH. Local address = i_cpu_addr - BASE, truncated to 13 bits.
- Out-of-range CPU request: o_cpu_ack=1 in the same cycle with no RAM access and no effect on the GPU. A read returns o_cpu_valid=1 with rdata=0 on the next cycle. A write is dropped.
- Arbitration (combinational, at most one RAM grant per cycle):
  - force_cpu = cpu_in_range_req && streak==STARVE_LIMIT.
  - grant_gpu = i_gpu_req && !force_cpu.
  - grant_cpu = cpu_in_range_req && !grant_gpu.
  - The out-of-range CPU path is independent and may ack in the same cycle as grant_gpu.
- Acks: o_gpu_ack=grant_gpu; o_cpu_ack=grant_cpu or out-of-range ack. Requests held without ack must keep address and data stable.
- RAM drive:
  - o_mem_en = grant_gpu|grant_cpu.
  - o_mem_we = grant_cpu&i_cpu_we.
  - o_mem_addr and o_mem_wdata are muxed from the winner. o_mem_wdata=0 when GPU wins.
- Streak counter (registered, 0..STARVE_LIMIT):
  - grant_gpu && cpu_in_range_req: streak+1, saturating.
  - grant_cpu, or no in-range CPU request pending: streak=0.
- Read return (1-cycle latency): an owner flag and a read flag are registered at grant. On the next cycle the owner's valid=1 and its rdata is captured from i_mem_rdata (or 0 for an out-of-range read). rdata holds its last value while valid=0. CPU writes never assert o_cpu_valid.
- Back-to-back: a new grant is allowed every cycle. The GPU may stream one read per cycle indefinitely when the CPU is idle.
- Simultaneous GPU and in-range CPU with streak<STARVE_LIMIT: GPU wins.
- Reset mid-operation: in-flight valids are dropped (0 the cycle after rst), and the streak clears.

Test Plan:
- Reset, then GPU read addr 0x0005 with RAM word 0x1234 at 5 -> o_gpu_ack same cycle; next cycle o_gpu_valid=1, o_gpu_rdata=0x1234; o_cpu_valid=0.
- CPU write 16384+10 data 0xBEEF, GPU idle -> o_mem_en=1, o_mem_we=1, o_mem_addr=10, o_mem_wdata=0xBEEF; no o_cpu_valid. A subsequent CPU read of 16394 returns 0xBEEF one cycle after ack.
- GPU requests every cycle plus CPU read held continuously -> 8 GPU acks, then CPU ack on the 9th contended cycle, then the GPU resumes; streak returns to 0 after the CPU grant.
- CPU read addr 24576 (out of range) while GPU reads -> both acked the same cycle; next cycle o_cpu_valid=1 rdata=0, o_gpu_valid=1; RAM sees only the GPU address.
- CPU write addr 100 (below BASE) -> ack, o_mem_en=0, RAM unchanged.
- rst asserted the cycle after a GPU read grant -> o_gpu_valid=0 the following cycle; streak=0.
